// File: rtl/change_dispenser_pkg.sv
// Shared coin values, FSM state encoding and coin one-hot type for the change dispenser.
// The piggy bank imports the same package so both sides agree on coin values.
package change_dispenser_pkg;

  localparam int CREDIT_W_DEF = 8;

  localparam int VAL_PENNY   = 1;
  localparam int VAL_NICKEL  = 5;
  localparam int VAL_DIME    = 10;
  localparam int VAL_QUARTER = 25;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_FINISH   = 2'd2
  } state_e;

  typedef struct packed {
    logic quarter;
    logic dime;
    logic nickel;
    logic penny;
  } coin_t;

  function automatic int coin_cents(input coin_t c);
    coin_cents = (c.quarter ? VAL_QUARTER : 0) + (c.dime ? VAL_DIME : 0)
               + (c.nickel ? VAL_NICKEL : 0) + (c.penny ? VAL_PENNY : 0);
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Refund request, coin-mechanism handshake and payout status between the bank side and the dispenser.
// The master drives the request and mech_ready; the slave (dispenser) drives coins and status.
interface change_dispenser_if #(
  parameter int CREDIT_W = 8
);
  logic                refund_req;
  logic [CREDIT_W-1:0] credit_in;
  logic                mech_ready;
  logic                penny;
  logic                nickel;
  logic                dime;
  logic                quarter;
  logic                busy;
  logic                done;
  logic [CREDIT_W-1:0] remaining;
  logic [3:0]          coin_count;

  modport master (
    output refund_req, credit_in, mech_ready,
    input  penny, nickel, dime, quarter, busy, done, remaining, coin_count
  );

  modport slave (
    input  refund_req, credit_in, mech_ready,
    output penny, nickel, dime, quarter, busy, done, remaining, coin_count
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin chooser: picks the largest coin not exceeding remaining, as one-hot plus its value.
// Remaining of zero selects no coin and a value of zero.
module change_dispenser_coin_select
  import change_dispenser_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic [CREDIT_W-1:0] remaining_i,
  output coin_t               coin_o,
  output logic [CREDIT_W-1:0] value_o
);

  always_comb begin
    coin_o  = '0;
    value_o = '0;
    if (remaining_i >= CREDIT_W'(VAL_QUARTER)) begin
      coin_o.quarter = 1'b1;
      value_o        = CREDIT_W'(VAL_QUARTER);
    end else if (remaining_i >= CREDIT_W'(VAL_DIME)) begin
      coin_o.dime = 1'b1;
      value_o     = CREDIT_W'(VAL_DIME);
    end else if (remaining_i >= CREDIT_W'(VAL_NICKEL)) begin
      coin_o.nickel = 1'b1;
      value_o       = CREDIT_W'(VAL_NICKEL);
    end else if (remaining_i >= CREDIT_W'(VAL_PENNY)) begin
      coin_o.penny = 1'b1;
      value_o      = CREDIT_W'(VAL_PENNY);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Refund payout engine: latches the credit on request and pays it out greedily as one-cycle coin
// pulses, throttled by the mechanism's ready line and a minimum idle gap between coins.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int CREDIT_W   = CREDIT_W_DEF,
  parameter int GAP_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  change_dispenser_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] remaining_q, remaining_d;
  logic [3:0]          count_q, count_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  coin_t               coin_q, coin_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  coin_t               sel_coin;
  logic [CREDIT_W-1:0] sel_value;
  logic                issue;

  change_dispenser_coin_select #(
    .CREDIT_W (CREDIT_W)
  ) u_coin_select (
    .remaining_i (remaining_q),
    .coin_o      (sel_coin),
    .value_o     (sel_value)
  );

  // remaining is never zero while dispensing, so a coin is always available when issuing
  assign issue = (state_q == ST_DISPENSE) && bus.mech_ready && (gap_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.refund_req) begin
          state_d = (bus.credit_in != '0) ? ST_DISPENSE : ST_FINISH;
        end
      end
      ST_DISPENSE: begin
        if (issue && (remaining_q == sel_value)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    remaining_d = remaining_q;
    count_d     = count_q;
    gap_d       = gap_q;
    coin_d      = '0;
    done_d      = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (bus.refund_req) begin
          remaining_d = bus.credit_in;
          count_d     = '0;
          gap_d       = '0;
        end
      end
      ST_DISPENSE: begin
        if (issue) begin
          coin_d      = sel_coin;
          remaining_d = remaining_q - sel_value;
          count_d     = count_q + 4'd1;
          gap_d       = GAP_W'(GAP_CYCLES);
        end else if (gap_q != '0) begin
          // the gap drains even while the mechanism is stalled
          gap_d = gap_q - 1'b1;
        end
      end
      ST_FINISH: begin
        done_d      = 1'b1;
        remaining_d = '0;
      end
      default: begin
        remaining_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      coin_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      coin_q      <= coin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.quarter    = coin_q.quarter;
  assign bus.dime       = coin_q.dime;
  assign bus.nickel     = coin_q.nickel;
  assign bus.penny      = coin_q.penny;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.remaining  = remaining_q;
  assign bus.coin_count = count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench: two dispensers (gap 1 and gap 0) driven through scripted refunds,
// each edge's coin pulse, remaining and done checked against hand-computed tables.
module tb_change_dispenser;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   cents_a;
  int   cents_b;

  localparam logic [3:0] Q = 4'b1000;
  localparam logic [3:0] D = 4'b0100;
  localparam logic [3:0] N = 4'b0010;
  localparam logic [3:0] P = 4'b0001;

  change_dispenser_if #(.CREDIT_W(8)) ifa ();
  change_dispenser_if #(.CREDIT_W(8)) ifb ();

  change_dispenser #(.CREDIT_W(8), .GAP_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  change_dispenser #(.CREDIT_W(8), .GAP_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [3:0] coins_a;
  logic [3:0] coins_b;
  assign coins_a = {ifa.quarter, ifa.dime, ifa.nickel, ifa.penny};
  assign coins_b = {ifb.quarter, ifb.dime, ifb.nickel, ifb.penny};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] ec [$];
  int         er [$];
  logic       mr [$];
  logic       rq [$];

  function automatic int cents_of(input logic [3:0] c);
    cents_of = (c[3] ? 25 : 0) + (c[2] ? 10 : 0) + (c[1] ? 5 : 0) + (c[0] ? 1 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cents_a += cents_of(coins_a);
    cents_b += cents_of(coins_b);
    chk("onehot_a", 32'($countones(coins_a) <= 1), 32'd1);
    chk("onehot_b", 32'($countones(coins_b) <= 1), 32'd1);
  endtask

  task automatic exp_a(input string tag, input logic [3:0] c, input int rem, input logic d);
    chk({tag, "_coins"}, 32'(coins_a), 32'(c));
    chk({tag, "_rem"}, 32'(ifa.remaining), rem);
    chk({tag, "_done"}, 32'(ifa.done), 32'(d));
  endtask

  task automatic accept_a(input string tag, input logic [7:0] credit, input logic mech);
    cents_a        = 0;
    ifa.credit_in  = credit;
    ifa.refund_req = 1'b1;
    ifa.mech_ready = mech;
    tick();
    ifa.refund_req = 1'b0;
    chk({tag, "_acc_busy"}, 32'(ifa.busy), 32'd1);
    chk({tag, "_acc_rem"}, 32'(ifa.remaining), 32'(credit));
    chk({tag, "_acc_coins"}, 32'(coins_a), 32'd0);
    chk({tag, "_acc_count"}, 32'(ifa.coin_count), 32'd0);
  endtask

  // plays the ec/er/mr/rq tables on dut_a; done is expected only on the final step
  task automatic run_a(input string tag);
    for (int i = 0; i < ec.size(); i++) begin
      ifa.mech_ready = mr[i];
      ifa.refund_req = rq[i];
      tick();
      exp_a($sformatf("%s_e%0d", tag, i + 1), ec[i], er[i], (i == ec.size() - 1));
    end
    ifa.refund_req = 1'b0;
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    cents_a = 0;
    cents_b = 0;
    rst     = 1'b1;
    ifa.refund_req = 1'b0; ifa.credit_in = '0; ifa.mech_ready = 1'b0;
    ifb.refund_req = 1'b0; ifb.credit_in = '0; ifb.mech_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_a("rst", 4'd0, 0, 1'b0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_count", 32'(ifa.coin_count), 32'd0);
    chk("rst_b_coins", 32'(coins_b), 32'd0);
    rst = 1'b0;
    tick();

    // credit 41 with a one-cycle gap between coins
    accept_a("t2", 8'd41, 1'b1);
    ec = '{Q, 4'd0, D, 4'd0, N, 4'd0, P, 4'd0};
    er = '{16, 16, 6, 6, 1, 1, 0, 0};
    mr = '{1, 1, 1, 1, 1, 1, 1, 1};
    rq = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_a("t2");
    chk("t2_count", 32'(ifa.coin_count), 32'd4);
    chk("t2_busy", 32'(ifa.busy), 32'd0);
    chk("t2_cents", 32'(cents_a), 32'd41);

    // reset after the first coin of 41 aborts the payout immediately
    accept_a("t1", 8'd41, 1'b1);
    tick();
    exp_a("t1_e1", Q, 16, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    exp_a("t1_rst", 4'd0, 0, 1'b0);
    chk("t1_rst_busy", 32'(ifa.busy), 32'd0);
    chk("t1_rst_count", 32'(ifa.coin_count), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_a($sformatf("t1_post%0d", i), 4'd0, 0, 1'b0);
      chk($sformatf("t1_post%0d_busy", i), 32'(ifa.busy), 32'd0);
    end
    accept_a("t1b", 8'd5, 1'b1);
    ec = '{N, 4'd0};
    er = '{0, 0};
    mr = '{1, 1};
    rq = '{0, 0};
    run_a("t1b");
    chk("t1b_count", 32'(ifa.coin_count), 32'd1);

    // credit 255 with no gap: ten quarters then a nickel back to back
    cents_b        = 0;
    ifb.credit_in  = 8'd255;
    ifb.refund_req = 1'b1;
    ifb.mech_ready = 1'b1;
    tick();
    ifb.refund_req = 1'b0;
    chk("t3_acc_rem", 32'(ifb.remaining), 32'd255);
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk($sformatf("t3_e%0d_coins", i), 32'(coins_b), 32'((i <= 10) ? Q : N));
      chk($sformatf("t3_e%0d_rem", i), 32'(ifb.remaining), 32'((i <= 10) ? (255 - 25 * i) : 0));
      chk($sformatf("t3_e%0d_done", i), 32'(ifb.done), 32'd0);
    end
    tick();
    chk("t3_done", 32'(ifb.done), 32'd1);
    chk("t3_coins_end", 32'(coins_b), 32'd0);
    chk("t3_count", 32'(ifb.coin_count), 32'd11);
    chk("t3_cents", 32'(cents_b), 32'd255);
    ifb.mech_ready = 1'b0;

    // zero credit: straight to done, no coins, count cleared
    accept_a("t4", 8'd0, 1'b1);
    ec = '{4'd0};
    er = '{0};
    mr = '{1};
    rq = '{0};
    run_a("t4");
    chk("t4_count", 32'(ifa.coin_count), 32'd0);
    chk("t4_cents", 32'(cents_a), 32'd0);

    // mechanism stalled for five cycles after accept
    accept_a("t5", 8'd30, 1'b0);
    ec = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, Q, 4'd0, N, 4'd0};
    er = '{30, 30, 30, 30, 30, 5, 5, 0, 0};
    mr = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    rq = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_a("t5");
    chk("t5_count", 32'(ifa.coin_count), 32'd2);
    chk("t5_cents", 32'(cents_a), 32'd30);

    // a second request with credit 99 during a payout of 16 is ignored
    accept_a("t6", 8'd16, 1'b1);
    ifa.credit_in = 8'd99;
    ec = '{D, 4'd0, N, 4'd0, P, 4'd0};
    er = '{6, 6, 1, 1, 0, 0};
    mr = '{1, 1, 1, 1, 1, 1};
    rq = '{0, 1, 1, 0, 0, 0};
    run_a("t6");
    chk("t6_count", 32'(ifa.coin_count), 32'd3);
    chk("t6_cents", 32'(cents_a), 32'd16);
    tick();
    chk("t6_idle_busy", 32'(ifa.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
